label_scanner: RTL and testbench
================================

// Module: label_scanner
// PURPOSE
//   Write-side producer for the label table. On start, walks program memory from address 0,
//   decodes LB (code label) and DATA (data label) words, and issues one label-table write
//   (lbidw/typw/basew/countw/we) per label found. Runs once after program load, before the core
//   executes; the core's pointer/branch logic reads the table afterwards.
// PARAMETERS
//   LBIDWidth   8      label id width; table holds 2**LBIDWidth entries
//   PROG_DEPTH  65536  program memory depth in words; scan stops at PROG_DEPTH-1
// PORTS
//   clk         in   1          single clock, all logic on posedge
//   rst_n       in   1          asynchronous active-low reset
//   start       in   1          1-cycle pulse; begins a scan when IDLE, ignored otherwise
//   busy        out  1          high from the cycle after start until DONE/ERR
//   done        out  1          1-cycle pulse on normal completion
//   err         out  1          sticky until next start; scan aborted
//   err_code    out  2          01 lbid out of range, 10 DATA overruns memory, 11 duplicate label
//   pm_addr     out  16         program memory read address
//   pm_re       out  1          read enable; pm_rdata valid exactly 1 cycle later
//   pm_rdata    in   32         program word
//   lt_we       out  1          label-table write strobe, 1 cycle per label
//   lt_lbidw    out  LBIDWidth  label id
//   lt_typw     out  6          label type (0 = code label)
//   lt_basew    out  16         base word address
//   lt_countw   out  16         element count
//   nlabels     out  LBIDWidth+1  labels written in current/last scan
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, pc 0. Reset mid-scan aborts; no further lt_we.
//   Encoding: opcode = word[31:24]. LB=8'h01: lbid=word[15:0]. DATA=8'h2E: typ=word[21:16],
//     lbid=word[15:0]; next word = count; count payload words follow. END=8'hFF.
//     Every other opcode is 1 word, skipped.
//   FSM: IDLE -start-> FETCH (pm_re=1, pm_addr=pc) -> DECODE (pm_rdata valid):
//     LB   -> EMIT(typ 0, base pc, count 1); pc+=1
//     DATA -> FETCH2 (pm_addr=pc+1) -> DECODE2 -> EMIT(typ, base pc+2, count); pc+=2+count
//     END  -> DONE;  other -> pc+=1, FETCH
//     EMIT: lt_we=1 for exactly one cycle, nlabels+=1, then FETCH (or DONE if pc wrapped past end).
//     DONE: done=1 one cycle, busy=0, -> IDLE.  ERR: err=1, busy=0, lt_we never asserted; -> IDLE.
//   Throughput: 2 cycles per skipped word; LB costs 3 cycles; DATA 5 cycles regardless of count.
//   lt_* data fields stable and valid in the lt_we cycle; hold last value otherwise.
//   Checks (in DECODE/DECODE2, before EMIT): lbid[15:LBIDWidth]!=0 -> ERR 01;
//     pc+2+count > PROG_DEPTH (17-bit compare) -> ERR 10. count=0 legal: base = pc+2.
//   End of memory: word at PROG_DEPTH-1 decoded, then DONE if no END seen. DATA whose count word
//     lies beyond memory -> ERR 10.
//   start during busy ignored; start in same cycle as done pulse ignored; new start clears err,
//     err_code, nlabels, pc.
// CONFIGURATION
//   LBSCAN_DUPCHECK_EN defined: 2**LBIDWidth-bit defined-vector, cleared on start; EMIT of an
//     already-set lbid -> ERR 11 instead of lt_we. Undefined: no vector, later label overwrites
//     earlier entry, err_code 11 never produced.
// STRUCTURE
//   Shared package/header: opcode constants OP_LB, OP_DATA, OP_END; TYP_CODE; err_code constants;
//     FSM state encoding. Single module; no sub-module (datapath is a pc adder and one compare).
// TESTING
//   Prog {LB 3, nop, END}, start -> lt_we once: lbid 3, typ 0, base 0, count 1; done; nlabels 1.
//   {DATA typ 5 lbid 7, count 4, 4 payload, LB 2, END} -> writes (7,5,base 2,count 4) then
//     (2,0,base 6,count 1); payload opcodes 8'h01 not decoded as LB.
//   LB lbid 16'h0100 with LBIDWidth 8 -> err, err_code 01, no lt_we, busy low, no done.
//   DATA at PROG_DEPTH-4 with count 8 -> err_code 10; DATA count 0 -> count 0, base pc+2.
//   rst_n low during EMIT-preceding DECODE -> lt_we stays 0, outputs 0; restart scan succeeds.
//   LB 3 twice: with LBSCAN_DUPCHECK_EN -> err_code 11 after one write; without -> two writes, done.

Source files
------------

// File: rtl/label_scanner_pkg.sv
// -----------------------------------------------------------------------------
// label_scanner_pkg
//   Shared constants for the label-table scanner: program word opcodes, the
//   label type used for code labels, error codes, FSM state encoding and a
//   small helper that checks whether a 16-bit label id fits the table.
// -----------------------------------------------------------------------------
package label_scanner_pkg;

    // Program word opcodes (word[31:24])
    localparam logic [7:0] OP_LB   = 8'h01;
    localparam logic [7:0] OP_DATA = 8'h2E;
    localparam logic [7:0] OP_END  = 8'hFF;

    // Label type written for code labels
    localparam logic [5:0] TYP_CODE = 6'd0;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LBID    = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_DUP     = 2'b11;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_FETCH2  = 3'd3;
    localparam logic [2:0] ST_DECODE2 = 3'd4;
    localparam logic [2:0] ST_EMIT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    // True when every bit of lbid at or above position 'width' is zero.
    function automatic logic lbid_fits(input logic [15:0] lbid, input int unsigned width);
        logic [31:0] wide;
        wide = {16'h0000, lbid};
        return ((wide >> width) == 32'd0);
    endfunction

endpackage

// File: rtl/label_scanner_if.sv
// -----------------------------------------------------------------------------
// label_scanner_if
//   Bundles the scanner's two memory-side buses:
//     pm_addr / pm_re / pm_rdata   program memory read port (data 1 cycle after re)
//     lt_we / lt_lbidw / lt_typw / lt_basew / lt_countw   label-table write port
//   master : the scanner (drives addresses and table writes, reads pm_rdata)
//   slave  : the memories (return pm_rdata, accept table writes)
// -----------------------------------------------------------------------------
interface label_scanner_if #(
    parameter int LBIDWidth = 8
);
    logic [15:0]          pm_addr;
    logic                 pm_re;
    logic [31:0]          pm_rdata;
    logic                 lt_we;
    logic [LBIDWidth-1:0] lt_lbidw;
    logic [5:0]           lt_typw;
    logic [15:0]          lt_basew;
    logic [15:0]          lt_countw;

    modport master (
        output pm_addr, pm_re, lt_we, lt_lbidw, lt_typw, lt_basew, lt_countw,
        input  pm_rdata
    );

    modport slave (
        input  pm_addr, pm_re, lt_we, lt_lbidw, lt_typw, lt_basew, lt_countw,
        output pm_rdata
    );
endinterface

// File: rtl/label_scanner.sv
// -----------------------------------------------------------------------------
// label_scanner
//   Walks program memory from address 0 after a start pulse, decodes LB (code
//   label) and DATA (data label) words and issues one label-table write per
//   label found. Stops on END, on the last memory word, or on an error.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             1-cycle pulse, accepted only when idle
//     busy              high while a scan is in progress
//     done              1-cycle pulse on normal completion
//     err, err_code     sticky abort flag and cause (01 lbid range,
//                       10 DATA overruns memory, 11 duplicate label)
//     bus               label_scanner_if.master: program read + table write
//     nlabels           labels written in the current/last scan
//
//   Optional feature: define LBSCAN_DUPCHECK_EN to track which label ids were
//   already written and abort with err_code 11 on a repeat. Without it a later
//   label simply overwrites the earlier table entry.
// -----------------------------------------------------------------------------
module label_scanner
    import label_scanner_pkg::*;
#(
    parameter int LBIDWidth  = 8,
    parameter int PROG_DEPTH = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    label_scanner_if.master        bus,
    output logic [LBIDWidth:0]     nlabels
);

    // Depth widened so pc+2+count never wraps in the overrun compare.
    localparam logic [17:0] DEPTH_C = 18'(PROG_DEPTH);

    // Registered state
    logic [2:0]           state_r;
    logic [16:0]          pc_r;
    logic [5:0]           typ_r;
    logic [LBIDWidth-1:0] lbid_r;
    logic [15:0]          pm_addr_r;
    logic                 pm_re_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic [1:0]           err_code_r;
    logic                 lt_we_r;
    logic [LBIDWidth-1:0] lt_lbidw_r;
    logic [5:0]           lt_typw_r;
    logic [15:0]          lt_basew_r;
    logic [15:0]          lt_countw_r;
    logic [LBIDWidth:0]   nlabels_r;

    // Next-state / decode signals
    logic [2:0]           state_s;
    logic [16:0]          pc_s;
    logic [15:0]          addr_s;
    logic [1:0]           errc_s;
    logic                 start_scan_s;
    logic [LBIDWidth-1:0] emit_lbid_s;
    logic [5:0]           emit_typ_s;
    logic [15:0]          emit_base_s;
    logic [15:0]          emit_count_s;
    logic [7:0]           opcode_s;
    logic [15:0]          lbid_full_s;
    logic [LBIDWidth-1:0] lbid_word_s;
    logic [17:0]          pc_plus1_s;
    logic [17:0]          data_end_s;
    logic                 dup_word_s;
    logic                 dup_held_s;
    logic                 unused_word_s;

    assign opcode_s    = bus.pm_rdata[31:24];
    assign lbid_full_s = bus.pm_rdata[15:0];
    assign lbid_word_s = bus.pm_rdata[LBIDWidth-1:0];
    assign pc_plus1_s  = {1'b0, pc_r} + 18'd1;
    // In DECODE2 pm_rdata holds the count word; pc still points at the DATA word.
    assign data_end_s  = {1'b0, pc_r} + 18'd2 + {2'b00, bus.pm_rdata[15:0]};
    // Bits 23:22 carry no meaning in any word format.
    assign unused_word_s = ^bus.pm_rdata[23:22];

`ifdef LBSCAN_DUPCHECK_EN
    logic [(2**LBIDWidth)-1:0] defined_r;

    // Look up whether the candidate label id was already written this scan.
    always_comb begin
        dup_word_s = defined_r[lbid_word_s];
        dup_held_s = defined_r[lbid_r];
    end

    // Defined-vector: cleared on start, marked when a label is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defined_r <= {(2**LBIDWidth){1'b0}};
        end else if (start_scan_s) begin
            defined_r <= {(2**LBIDWidth){1'b0}};
        end else if (state_s == ST_EMIT) begin
            defined_r[emit_lbid_s] <= 1'b1;
        end else begin
            defined_r <= defined_r;
        end
    end
`else
    assign dup_word_s = 1'b0;
    assign dup_held_s = 1'b0;
`endif

    // Next-state, next-pc and emit-field decode.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        addr_s       = pm_addr_r;
        errc_s       = err_code_r;
        start_scan_s = 1'b0;
        emit_lbid_s  = lt_lbidw_r;
        emit_typ_s   = lt_typw_r;
        emit_base_s  = lt_basew_r;
        emit_count_s = lt_countw_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_scan_s = 1'b1;
                    state_s      = ST_FETCH;
                    pc_s         = 17'd0;
                    addr_s       = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                state_s = ST_DECODE;
            end

            ST_DECODE: begin
                case (opcode_s)
                    OP_LB: begin
                        if (!lbid_fits(lbid_full_s, LBIDWidth)) begin
                            state_s = ST_ERR;
                            errc_s  = ERR_LBID;
                        end else if (dup_word_s) begin
                            state_s = ST_ERR;
                            errc_s  = ERR_DUP;
                        end else begin
                            state_s      = ST_EMIT;
                            emit_lbid_s  = lbid_word_s;
                            emit_typ_s   = TYP_CODE;
                            emit_base_s  = pc_r[15:0];
                            emit_count_s = 16'd1;
                            pc_s         = pc_plus1_s[16:0];
                        end
                    end
                    OP_DATA: begin
                        if (!lbid_fits(lbid_full_s, LBIDWidth)) begin
                            state_s = ST_ERR;
                            errc_s  = ERR_LBID;
                        end else if (pc_plus1_s >= DEPTH_C) begin
                            // Count word would sit past the last address.
                            state_s = ST_ERR;
                            errc_s  = ERR_OVERRUN;
                        end else begin
                            state_s = ST_FETCH2;
                            addr_s  = pc_plus1_s[15:0];
                        end
                    end
                    OP_END: begin
                        state_s = ST_DONE;
                    end
                    default: begin
                        pc_s = pc_plus1_s[16:0];
                        if (pc_plus1_s >= DEPTH_C) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_FETCH;
                            addr_s  = pc_plus1_s[15:0];
                        end
                    end
                endcase
            end

            ST_FETCH2: begin
                state_s = ST_DECODE2;
            end

            ST_DECODE2: begin
                if (data_end_s > DEPTH_C) begin
                    state_s = ST_ERR;
                    errc_s  = ERR_OVERRUN;
                end else if (dup_held_s) begin
                    state_s = ST_ERR;
                    errc_s  = ERR_DUP;
                end else begin
                    state_s      = ST_EMIT;
                    emit_lbid_s  = lbid_r;
                    emit_typ_s   = typ_r;
                    emit_base_s  = 16'(pc_r + 17'd2);
                    emit_count_s = bus.pm_rdata[15:0];
                    pc_s         = data_end_s[16:0];
                end
            end

            ST_EMIT: begin
                // pc already points past the label; stop if it ran off the end.
                if ({1'b0, pc_r} >= DEPTH_C) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FETCH;
                    addr_s  = pc_r[15:0];
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            ST_ERR: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, pc and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= 17'd0;
            pm_addr_r  <= 16'd0;
            pm_re_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            lt_we_r    <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            nlabels_r  <= {(LBIDWidth+1){1'b0}};
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            pm_addr_r <= addr_s;
            pm_re_r   <= (state_s == ST_FETCH) || (state_s == ST_FETCH2);
            busy_r    <= (state_s != ST_IDLE) && (state_s != ST_DONE) && (state_s != ST_ERR);
            done_r    <= (state_s == ST_DONE);
            lt_we_r   <= (state_s == ST_EMIT);

            if (start_scan_s) begin
                err_r      <= 1'b0;
                err_code_r <= ERR_NONE;
            end else if (state_s == ST_ERR) begin
                err_r      <= 1'b1;
                err_code_r <= errc_s;
            end else begin
                err_r      <= err_r;
                err_code_r <= err_code_r;
            end

            if (start_scan_s) begin
                nlabels_r <= {(LBIDWidth+1){1'b0}};
            end else if (state_s == ST_EMIT) begin
                nlabels_r <= nlabels_r + {{LBIDWidth{1'b0}}, 1'b1};
            end else begin
                nlabels_r <= nlabels_r;
            end
        end
    end

    // Table write fields: loaded on entry to EMIT, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_lbidw_r  <= {LBIDWidth{1'b0}};
            lt_typw_r   <= 6'd0;
            lt_basew_r  <= 16'd0;
            lt_countw_r <= 16'd0;
        end else if (state_s == ST_EMIT) begin
            lt_lbidw_r  <= emit_lbid_s;
            lt_typw_r   <= emit_typ_s;
            lt_basew_r  <= emit_base_s;
            lt_countw_r <= emit_count_s;
        end else begin
            lt_lbidw_r  <= lt_lbidw_r;
            lt_typw_r   <= lt_typw_r;
            lt_basew_r  <= lt_basew_r;
            lt_countw_r <= lt_countw_r;
        end
    end

    // DATA header fields kept while the count word is fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ_r  <= 6'd0;
            lbid_r <= {LBIDWidth{1'b0}};
        end else if (state_r == ST_DECODE) begin
            typ_r  <= bus.pm_rdata[21:16];
            lbid_r <= lbid_word_s;
        end else begin
            typ_r  <= typ_r;
            lbid_r <= lbid_r;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign err_code      = err_code_r;
    assign nlabels       = nlabels_r;
    assign bus.pm_addr   = pm_addr_r;
    assign bus.pm_re     = pm_re_r;
    assign bus.lt_we     = lt_we_r;
    assign bus.lt_lbidw  = lt_lbidw_r;
    assign bus.lt_typw   = lt_typw_r;
    assign bus.lt_basew  = lt_basew_r;
    assign bus.lt_countw = lt_countw_r;

endmodule

// File: tb/tb_label_scanner.sv
// -----------------------------------------------------------------------------
// tb_label_scanner
//   Drives label_scanner against a small program memory. A reference walk of
//   the program array predicts the label writes, final status, label count and
//   scan latency; directed programs cover the documented corner cases and
//   random programs cover the rest.
// -----------------------------------------------------------------------------
module tb_label_scanner;

    localparam int LBW   = 8;
    localparam int DEPTH = 64;
`ifdef LBSCAN_DUPCHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, err;
    logic [1:0]     err_code;
    logic [LBW:0]   nlabels;

    label_scanner_if #(.LBIDWidth(LBW)) bus ();

    label_scanner #(.LBIDWidth(LBW), .PROG_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .bus      (bus.master),
        .nlabels  (nlabels)
    );

    always #5 clk = ~clk;

    // Program memory: registered read, data one cycle after pm_re.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.pm_re) bus.pm_rdata <= mem[bus.pm_addr[5:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed table writes {lbid, typ, base, count}
    logic [45:0] obs_q [$];
    logic [45:0] exp_q [$];
    always @(negedge clk) begin
        if (rst_n && bus.lt_we)
            obs_q.push_back({bus.lt_lbidw, bus.lt_typw, bus.lt_basew, bus.lt_countw});
    end

    function automatic logic [31:0] w_lb(input logic [15:0] id);
        return {8'h01, 8'h00, id};
    endfunction
    function automatic logic [31:0] w_data(input logic [5:0] typ, input logic [15:0] id);
        return {8'h2E, 2'b00, typ, id};
    endfunction
    localparam logic [31:0] W_END = 32'hFF00_0000;
    localparam logic [31:0] W_NOP = 32'h0000_0000;

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = W_NOP;
    endtask

    // Reference: walk the program word by word from the format rules.
    logic [1:0] exp_err;
    int         exp_cyc;
    int         exp_nl;
    task automatic model_scan();
        int pc; int lb; int cnt; bit fin; bit seen [256];
        logic [31:0] w; logic [31:0] cw;
        foreach (seen[i]) seen[i] = 1'b0;
        exp_q.delete();
        exp_err = 2'b00; exp_cyc = 0; pc = 0; fin = 1'b0;
        while (!fin && pc < DEPTH) begin
            w  = mem[pc];
            lb = int'(w[15:0]);
            case (w[31:24])
                8'h01: begin
                    if (lb >= 256) begin exp_err = 2'b01; fin = 1'b1; end
                    else if (DUP && seen[lb]) begin exp_err = 2'b11; fin = 1'b1; end
                    else begin
                        seen[lb] = 1'b1;
                        exp_q.push_back({lb[7:0], 6'd0, 16'(pc), 16'd1});
                        pc += 1; exp_cyc += 3;
                    end
                end
                8'h2E: begin
                    if (lb >= 256) begin exp_err = 2'b01; fin = 1'b1; end
                    else if (pc + 1 >= DEPTH) begin exp_err = 2'b10; fin = 1'b1; end
                    else begin
                        cw  = mem[pc+1];
                        cnt = int'(cw[15:0]);
                        if (pc + 2 + cnt > DEPTH) begin exp_err = 2'b10; fin = 1'b1; end
                        else if (DUP && seen[lb]) begin exp_err = 2'b11; fin = 1'b1; end
                        else begin
                            seen[lb] = 1'b1;
                            exp_q.push_back({lb[7:0], w[21:16], 16'(pc + 2), 16'(cnt)});
                            pc += 2 + cnt; exp_cyc += 5;
                        end
                    end
                end
                8'hFF: begin exp_cyc += 2; fin = 1'b1; end
                default: begin pc += 1; exp_cyc += 2; end
            endcase
        end
        exp_nl = exp_q.size();
    endtask

    // Run one scan of the current memory and compare everything to the model.
    task automatic run_scan(input string tag, input bit extra_start);
        int cyc; bit timed_out; int n_before;
        obs_q.delete();
        model_scan();
        @(negedge clk); start = 1'b1;
        cyc = 0; timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (i == 0) check_eq({tag, ":busy_start"}, busy, 1'b1);
            if (extra_start && i == 1) start = 1'b1;
            if (done || err) begin timed_out = 1'b0; break; end
        end
        start = 1'b0;
        if (timed_out) begin
            check_eq({tag, ":timeout"}, 1'b1, 1'b0);
            return;
        end
        check_eq({tag, ":err"}, err, exp_err != 2'b00);
        check_eq({tag, ":err_code"}, err_code, exp_err);
        check_eq({tag, ":done"}, done, exp_err == 2'b00);
        check_eq({tag, ":busy_end"}, busy, 1'b0);
        check_eq({tag, ":nlabels"}, nlabels, exp_nl);
        check_eq({tag, ":nwrites"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check_eq($sformatf("%s:write%0d", tag, k), obs_q[k], exp_q[k]);
        if (exp_err == 2'b00) begin
            check_eq({tag, ":latency"}, cyc - 1, exp_cyc);
            // start coinciding with the done pulse must not launch a scan
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            check_eq({tag, ":start_on_done"}, busy, 1'b0);
        end
        n_before = obs_q.size();
        repeat (3) @(negedge clk);
        check_eq({tag, ":no_late_we"}, obs_q.size(), n_before);
        check_eq({tag, ":err_sticky"}, err, exp_err != 2'b00);
        check_eq({tag, ":done_pulse"}, done, 1'b0);
    endtask

    function automatic logic [15:0] rand_lbid();
        if ($urandom_range(0, 29) == 0) return 16'($urandom_range(256, 65535));
        return 16'($urandom_range(0, 24));
    endfunction

    task automatic gen_random();
        int i; int r; int cnt;
        clear_mem();
        i = 0;
        while (i < DEPTH) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                mem[i] = w_lb(rand_lbid()); i++;
            end else if (r < 32) begin
                mem[i] = w_data(6'($urandom_range(0, 63)), rand_lbid());
                cnt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 4);
                if (i + 1 < DEPTH) mem[i+1] = {16'($urandom), 16'(cnt)};
                for (int j = 0; j < cnt; j++)
                    if (i + 2 + j < DEPTH)
                        mem[i+2+j] = ($urandom_range(0, 1) == 1) ? w_lb(rand_lbid()) : $urandom;
                i += 2 + cnt;
            end else if (r < 35) begin
                mem[i] = W_END; i++;
            end else begin
                mem[i] = {8'($urandom_range(2, 45)), 24'($urandom)}; i++;
            end
        end
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check_eq("reset:busy", busy, 1'b0);
        check_eq("reset:done", done, 1'b0);
        check_eq("reset:err", {err, err_code}, 3'b000);
        check_eq("reset:nlabels", nlabels, 0);
        check_eq("reset:pm", {bus.pm_re, bus.pm_addr}, 17'd0);
        check_eq("reset:lt", {bus.lt_we, bus.lt_lbidw, bus.lt_typw, bus.lt_basew, bus.lt_countw}, 47'd0);
        rst_n = 1'b1;

        // LB 3, nop, END
        clear_mem();
        mem[0] = w_lb(16'd3); mem[1] = W_NOP; mem[2] = W_END;
        run_scan("lb_basic", 1'b0);

        // DATA typ 5 lbid 7 count 4 with LB-looking payload, then LB 2, END
        clear_mem();
        mem[0] = w_data(6'd5, 16'd7); mem[1] = 32'd4;
        for (int i = 2; i < 6; i++) mem[i] = w_lb(16'(i + 40));
        mem[6] = w_lb(16'd2); mem[7] = W_END;
        run_scan("data_lb", 1'b1);

        // lbid out of range
        clear_mem();
        mem[0] = w_lb(16'h0100); mem[1] = W_END;
        run_scan("lbid_range", 1'b0);

        // DATA near the end overrunning memory
        clear_mem();
        mem[DEPTH-4] = w_data(6'd1, 16'd9); mem[DEPTH-3] = 32'd8;
        run_scan("data_overrun", 1'b0);

        // DATA count 0
        clear_mem();
        mem[0] = W_NOP; mem[1] = w_data(6'd3, 16'd4); mem[2] = 32'd0; mem[3] = W_END;
        run_scan("data_cnt0", 1'b0);

        // End of memory without END: LB in the last word
        clear_mem();
        mem[DEPTH-1] = w_lb(16'd200);
        run_scan("end_of_mem", 1'b0);

        // DATA in the last word: count word beyond memory
        clear_mem();
        mem[DEPTH-1] = w_data(6'd2, 16'd1);
        run_scan("data_last", 1'b0);

        // DATA count 0 exactly reaching the end
        clear_mem();
        mem[DEPTH-2] = w_data(6'd7, 16'd11); mem[DEPTH-1] = 32'd0;
        run_scan("data_edge", 1'b0);

        // Duplicate label
        clear_mem();
        mem[0] = w_lb(16'd3); mem[1] = w_lb(16'd3); mem[2] = W_END;
        run_scan("dup", 1'b0);

        // Reset in the DECODE cycle before an EMIT
        clear_mem();
        mem[0] = w_lb(16'd3); mem[1] = W_END;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_eq("midrst:outs", {busy, done, err, err_code, nlabels}, 14'd0);
        check_eq("midrst:pm", {bus.pm_re, bus.pm_addr}, 17'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst:no_we", bus.lt_we, 1'b0);
        end
        rst_n = 1'b1;
        run_scan("after_rst", 1'b0);

        // Random programs
        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_scan($sformatf("rand%0d", t), t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
